rob_multiway: RTL and testbench
===============================

Name: rob_multiway

Overview:
Parametrised N-way reorder buffer: dispatch, completion and retirement widths are generics, and the buffer exposes an explicit occupancy count.
- Sits between dispatch (map table / RS) and retire (arch regfile, fetch redirect).
- Adds wrap-bit full/empty tracking, per-entry source-operand lookup and retire-stop on branch/halt.
- Raises its own flush request on a retired taken branch.

Parameters:
ROB_DEPTH, 32, number of entries; power of two, >= 2*DP_WIDTH
DP_WIDTH, 3, dispatch and retire lanes per cycle
CDB_WIDTH, 3, completion lanes per cycle
XLEN, 32, data width
REG_W, 5, architectural register index width

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous active-high reset
squash  in  1  external full flush
dp_valid  in  DP_WIDTH  lane wants allocation; lanes must be contiguous from lane 0
dp_dest_valid  in  DP_WIDTH  lane writes a register
dp_dest_idx  in  DP_WIDTH*REG_W  destination register
dp_accept  out  DP_WIDTH  lane allocated this cycle
dp_tag  out  DP_WIDTH*log2(ROB_DEPTH)  tag assigned to each lane (tail+i)
cdb_valid  in  CDB_WIDTH  completion valid
cdb_tag  in  CDB_WIDTH*log2(ROB_DEPTH)  completing entry
cdb_value  in  CDB_WIDTH*XLEN  result
cdb_take_branch  in  CDB_WIDTH  resolved mispredict / redirect
cdb_npc  in  CDB_WIDTH*XLEN  redirect target
cdb_halt  in  CDB_WIDTH  halt instruction
lu_tag  in  2*DP_WIDTH*log2(ROB_DEPTH)  operand tags to query
lu_ready  out  2*DP_WIDTH  queried entry busy and completed
lu_value  out  2*DP_WIDTH*XLEN  queried entry value
rt_valid  out  DP_WIDTH  lane retires this cycle
rt_dest_idx  out  DP_WIDTH*REG_W  0 when no destination
rt_value  out  DP_WIDTH*XLEN
rt_npc  out  XLEN  redirect target of retiring branch
rt_squash  out  1  retired entry had take_branch
rt_halt  out  1  retired entry had halt
free_count  out  log2(ROB_DEPTH)+1  free entries, from registered state

Behaviour:
- Reset:
  - Applies when reset is high at a clock edge.
  - All entries invalid; head = tail = 0 including wrap bits.
  - Outputs: free_count = ROB_DEPTH; all rt_*, lu_ready, dp_accept = 0.
  - Reset mid-operation discards everything, including a same-cycle dispatch or completion.
- Pointers: head/tail are log2(ROB_DEPTH)+1 bits.
  - Empty when the two are equal.
  - Full when the index bits are equal and the wrap bits differ.
  - Occupancy = tail - head (mod 2*ROB_DEPTH).
- Dispatch:
  - accepted = min(popcount-prefix of dp_valid, free_count, DP_WIDTH).
  - dp_accept, dp_tag and free_count are combinational from registered state.
  - Slots freed by this cycle's retirement are not reusable until next cycle.
  - Accepted lanes write busy = 1, done = 0 and dest at tail+i (mod depth) at the edge.
- Completion:
  - Each valid CDB lane whose tag is busy writes done, value, take_branch, npc and halt.
  - A lane whose tag is not busy is ignored.
  - Duplicate tags in one cycle are illegal (assertion); if they occur, the higher lane index wins.
- Retire (combinational from registered state):
  - Lane i retires iff entries head..head+i are all busy and done.
  - Retirement stops after the first retiring entry with take_branch or halt; that entry retires, the younger ones do not.
  - A completion and a retire of the same entry in one cycle is impossible: completion is visible to retire one cycle later.
- Flush:
  - squash input or rt_squash: next state is empty (head = tail = 0).
  - The concurrent dispatch is dropped.
  - The concurrent retirement is still reported on rt_*.
  - rt_npc is valid only when rt_squash = 1.
- Lookup:
  - lu_ready = entry busy and done; lu_value reads the registered entry.
  - Tag 0 is not special; the caller gates validity.
- Wrap-around: all indices are taken modulo ROB_DEPTH; a dispatch or retire group may straddle entry ROB_DEPTH-1 to 0.

Optional Feature:
ROB_CDB_BYPASS_EN.
- Defined: lu_ready/lu_value also match same-cycle cdb_valid lanes by tag, with the CDB taking priority over stored data.
- Undefined: lookup sees registered state only, one cycle later.

Decomposition:
- Shared package rob_pkg:
  - rob_entry_t (busy, done, dest_idx, value, take_branch, npc, halt).
  - Tag typedef sized from ROB_DEPTH.
  - Pointer typedef with wrap bit.
- One natural sub-module, rob_retire_select: prefix-AND of done plus branch/halt stop mask producing rt_valid and the retire count.

Test Plan:
- Reset, then dispatch 3 lanes with dest 5,6,7 -> dp_tag 0,1,2; free_count 32 -> 29 next cycle.
- Complete tags 1,2 only -> no retire. Complete tag 0 -> next cycle rt_valid = 111, rt_dest_idx 5,6,7, free_count back to 32.
- Fill to 30 entries, offer 3 lanes -> dp_accept = 011. Next cycle full -> dp_accept = 000 and free_count = 0, with head/tail index bits equal.
- Head at 30, dispatch 3, complete all -> tags 30,31,0 retire in one cycle across the wrap.
- Tags 0..2 done, tag 1 with take_branch and npc 0x100 -> retire lanes 0,1 only; rt_squash = 1, rt_npc = 0x100; next cycle empty and free_count = 32.
- With ROB_CDB_BYPASS_EN: lu_tag 4 while cdb tag 4 value 0xDEAD is valid -> same-cycle lu_ready = 1 and lu_value = 0xDEAD. Without it -> lu_ready = 0 that cycle.

Source files
------------

// File: rtl/rob_pkg.sv
// Shared types and sizing for the multi-lane reorder buffer.
// Every sizing constant below is the single source for the interface, top and retire selector.
package rob_pkg;

  localparam int ROB_DEPTH = 32;
  localparam int DP_WIDTH  = 3;
  localparam int CDB_WIDTH = 3;
  localparam int XLEN      = 32;
  localparam int REG_W     = 5;

  localparam int TAG_W    = $clog2(ROB_DEPTH);
  localparam int PTR_W    = TAG_W + 1;
  localparam int CNT_W    = TAG_W + 1;
  localparam int LU_N     = 2 * DP_WIDTH;
  localparam int RT_CNT_W = $clog2(DP_WIDTH + 1);

  typedef logic [TAG_W-1:0]    tag_t;
  typedef logic [PTR_W-1:0]    ptr_t;     // index bits plus wrap bit
  typedef logic [CNT_W-1:0]    cnt_t;
  typedef logic [RT_CNT_W-1:0] rt_cnt_t;
  typedef logic [REG_W-1:0]    reg_idx_t;
  typedef logic [XLEN-1:0]     word_t;

  typedef struct packed {
    logic     busy;
    logic     done;
    reg_idx_t dest_idx;
    word_t    value;
    logic     take_branch;
    word_t    npc;
    logic     halt;
  } rob_entry_t;

  // A lane without a destination stores index 0 so retire reports 0.
  function automatic rob_entry_t new_entry(logic dest_valid, reg_idx_t dest_idx);
    rob_entry_t e;
    e          = '0;
    e.busy     = 1'b1;
    e.dest_idx = dest_valid ? dest_idx : '0;
    return e;
  endfunction

endpackage

// File: rtl/rob_multiway_if.sv
// Dispatch, completion, lookup and retire bundle of the reorder buffer.
// master is the pipeline side, slave is the reorder buffer.
interface rob_multiway_if;
  import rob_pkg::*;

  logic                   squash;

  logic [DP_WIDTH-1:0]    dp_valid;
  logic [DP_WIDTH-1:0]    dp_dest_valid;
  reg_idx_t [DP_WIDTH-1:0] dp_dest_idx;
  logic [DP_WIDTH-1:0]    dp_accept;
  tag_t [DP_WIDTH-1:0]    dp_tag;

  logic [CDB_WIDTH-1:0]   cdb_valid;
  tag_t [CDB_WIDTH-1:0]   cdb_tag;
  word_t [CDB_WIDTH-1:0]  cdb_value;
  logic [CDB_WIDTH-1:0]   cdb_take_branch;
  word_t [CDB_WIDTH-1:0]  cdb_npc;
  logic [CDB_WIDTH-1:0]   cdb_halt;

  tag_t [LU_N-1:0]        lu_tag;
  logic [LU_N-1:0]        lu_ready;
  word_t [LU_N-1:0]       lu_value;

  logic [DP_WIDTH-1:0]    rt_valid;
  reg_idx_t [DP_WIDTH-1:0] rt_dest_idx;
  word_t [DP_WIDTH-1:0]   rt_value;
  word_t                  rt_npc;
  logic                   rt_squash;
  logic                   rt_halt;
  cnt_t                   free_count;

  modport master (
    output squash, dp_valid, dp_dest_valid, dp_dest_idx,
    output cdb_valid, cdb_tag, cdb_value, cdb_take_branch, cdb_npc, cdb_halt,
    output lu_tag,
    input  dp_accept, dp_tag, lu_ready, lu_value,
    input  rt_valid, rt_dest_idx, rt_value, rt_npc, rt_squash, rt_halt, free_count
  );

  modport slave (
    input  squash, dp_valid, dp_dest_valid, dp_dest_idx,
    input  cdb_valid, cdb_tag, cdb_value, cdb_take_branch, cdb_npc, cdb_halt,
    input  lu_tag,
    output dp_accept, dp_tag, lu_ready, lu_value,
    output rt_valid, rt_dest_idx, rt_value, rt_npc, rt_squash, rt_halt, free_count
  );

endinterface

// File: rtl/rob_retire_select.sv
// In-order retire lane selection: prefix-AND of busy&done, cut after the
// first retiring entry that carries a branch redirect or halt.
module rob_retire_select
  import rob_pkg::*;
(
  input  logic [DP_WIDTH-1:0] ready_i,
  input  logic [DP_WIDTH-1:0] stop_i,
  output logic [DP_WIDTH-1:0] rt_valid_o,
  output rt_cnt_t             rt_count_o
);

  logic run;

  always_comb begin
    run        = 1'b1;
    rt_valid_o = '0;
    rt_count_o = '0;
    for (int i = 0; i < DP_WIDTH; i++) begin
      if (run && ready_i[i]) begin
        rt_valid_o[i] = 1'b1;
        rt_count_o    = rt_count_o + rt_cnt_t'(1);
        run           = !stop_i[i];
      end else begin
        run = 1'b0;
      end
    end
  end

endmodule

// File: rtl/rob_multiway.sv
// Multi-lane reorder buffer with wrap-bit pointers, operand lookup and retire-stop.
// Define ROB_CDB_BYPASS_EN to forward same-cycle CDB results to operand lookup.
module rob_multiway
  import rob_pkg::*;
(
  input  logic           clock,
  input  logic           reset,
  rob_multiway_if.slave  rob
);

  ptr_t       head_q, head_d;
  ptr_t       tail_q, tail_d;
  rob_entry_t entries_q [ROB_DEPTH];

  cnt_t                occupancy;
  cnt_t                free_cnt;
  logic [DP_WIDTH-1:0] dp_accept;
  tag_t [DP_WIDTH-1:0] dp_tag;
  rt_cnt_t             acc_cnt;
  logic                dp_run;

  tag_t [DP_WIDTH-1:0] rt_tag;
  logic [DP_WIDTH-1:0] rt_ready;
  logic [DP_WIDTH-1:0] rt_stop;
  logic [DP_WIDTH-1:0] rt_valid;
  rt_cnt_t             rt_cnt;
  logic                rt_squash;
  logic                flush;
  logic                cdb_dup;

  // Equal pointers mean empty; equal index with differing wrap bits means full.
  assign occupancy = cnt_t'(tail_q - head_q);
  assign free_cnt  = cnt_t'(ROB_DEPTH) - occupancy;

  // Allocation uses only registered free space, so same-cycle retire slots wait a cycle.
  always_comb begin
    dp_run    = 1'b1;
    dp_accept = '0;
    acc_cnt   = '0;
    for (int i = 0; i < DP_WIDTH; i++) begin
      dp_tag[i] = tag_t'(tail_q) + tag_t'(i);
      dp_run    = dp_run & rob.dp_valid[i];
      if (dp_run && (cnt_t'(i) < free_cnt)) begin
        dp_accept[i] = 1'b1;
        acc_cnt      = acc_cnt + rt_cnt_t'(1);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DP_WIDTH; i++) begin
      rt_tag[i]   = tag_t'(head_q) + tag_t'(i);
      rt_ready[i] = entries_q[rt_tag[i]].busy & entries_q[rt_tag[i]].done;
      rt_stop[i]  = entries_q[rt_tag[i]].take_branch | entries_q[rt_tag[i]].halt;
    end
  end

  rob_retire_select u_retire_select (
    .ready_i    (rt_ready),
    .stop_i     (rt_stop),
    .rt_valid_o (rt_valid),
    .rt_count_o (rt_cnt)
  );

  always_comb begin
    rt_squash       = 1'b0;
    rob.rt_halt     = 1'b0;
    rob.rt_npc      = '0;
    rob.rt_dest_idx = '0;
    rob.rt_value    = '0;
    for (int i = 0; i < DP_WIDTH; i++) begin
      if (rt_valid[i]) begin
        rob.rt_dest_idx[i] = entries_q[rt_tag[i]].dest_idx;
        rob.rt_value[i]    = entries_q[rt_tag[i]].value;
        if (entries_q[rt_tag[i]].take_branch) begin
          rt_squash  = 1'b1;
          rob.rt_npc = entries_q[rt_tag[i]].npc;
        end
        if (entries_q[rt_tag[i]].halt) begin
          rob.rt_halt = 1'b1;
        end
      end
    end
  end

  assign flush  = rob.squash | rt_squash;
  assign head_d = head_q + ptr_t'(rt_cnt);
  assign tail_d = tail_q + ptr_t'(acc_cnt);

  // Later loop iterations win, so a duplicated CDB tag resolves to the higher lane.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      head_q <= '0;
      tail_q <= '0;
      for (int e = 0; e < ROB_DEPTH; e++) begin
        entries_q[e] <= '0;
      end
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      for (int i = 0; i < DP_WIDTH; i++) begin
        if (rt_valid[i]) begin
          entries_q[rt_tag[i]].busy <= 1'b0;
          entries_q[rt_tag[i]].done <= 1'b0;
        end
      end
      for (int c = 0; c < CDB_WIDTH; c++) begin
        if (rob.cdb_valid[c] && entries_q[rob.cdb_tag[c]].busy) begin
          entries_q[rob.cdb_tag[c]].done        <= 1'b1;
          entries_q[rob.cdb_tag[c]].value       <= rob.cdb_value[c];
          entries_q[rob.cdb_tag[c]].take_branch <= rob.cdb_take_branch[c];
          entries_q[rob.cdb_tag[c]].npc         <= rob.cdb_npc[c];
          entries_q[rob.cdb_tag[c]].halt        <= rob.cdb_halt[c];
        end
      end
      for (int i = 0; i < DP_WIDTH; i++) begin
        if (dp_accept[i]) begin
          entries_q[dp_tag[i]] <= new_entry(rob.dp_dest_valid[i], rob.dp_dest_idx[i]);
        end
      end
    end
  end

  always_comb begin
    for (int j = 0; j < LU_N; j++) begin
      rob.lu_ready[j] = entries_q[rob.lu_tag[j]].busy & entries_q[rob.lu_tag[j]].done;
      rob.lu_value[j] = entries_q[rob.lu_tag[j]].value;
`ifdef ROB_CDB_BYPASS_EN
      for (int c = 0; c < CDB_WIDTH; c++) begin
        if (rob.cdb_valid[c] && (rob.cdb_tag[c] == rob.lu_tag[j]) &&
            entries_q[rob.lu_tag[j]].busy) begin
          rob.lu_ready[j] = 1'b1;
          rob.lu_value[j] = rob.cdb_value[c];
        end
      end
`endif
    end
  end

  always_comb begin
    cdb_dup = 1'b0;
    for (int a = 0; a < CDB_WIDTH; a++) begin
      for (int b = a + 1; b < CDB_WIDTH; b++) begin
        if (rob.cdb_valid[a] && rob.cdb_valid[b] && (rob.cdb_tag[a] == rob.cdb_tag[b])) begin
          cdb_dup = 1'b1;
        end
      end
    end
  end

  assert property (@(posedge clock) disable iff (reset) !cdb_dup);

  assign rob.dp_accept  = dp_accept;
  assign rob.dp_tag     = dp_tag;
  assign rob.rt_valid   = rt_valid;
  assign rob.rt_squash  = rt_squash;
  assign rob.free_count = free_cnt;

endmodule

// File: tb/tb_rob_multiway.sv
// Directed bench for rob_multiway: cycle vector table plus hand-written
// sequences for full, wrap-around, halt, lookup bypass and mid-run reset.
module tb_rob_multiway;

  logic clock = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  rob_multiway_if bus();

  rob_multiway dut (
    .clock (clock),
    .reset (reset),
    .rob   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0] dpv;
    logic [4:0] d0, d1, d2;
    logic [2:0] cv;
    logic [4:0] t0, t1, t2;
    logic [2:0] cbr;
    logic [4:0] lut;
    logic [2:0] acc;
    logic [4:0] tag0;
    logic [5:0] free;
    logic [2:0] rtv;
    logic [4:0] r0, r1, r2;
    logic       sq;
    logic       lur;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic clr();
    bus.squash          = 1'b0;
    bus.dp_valid        = '0;
    bus.dp_dest_valid   = '0;
    bus.dp_dest_idx     = '0;
    bus.cdb_valid       = '0;
    bus.cdb_tag         = '0;
    bus.cdb_value       = '0;
    bus.cdb_take_branch = '0;
    bus.cdb_npc         = '0;
    bus.cdb_halt        = '0;
    bus.lu_tag          = '0;
  endtask

  task automatic set_dp(input logic [2:0] v, input logic [4:0] d0, d1, d2);
    bus.dp_valid       = v;
    bus.dp_dest_valid  = v;
    bus.dp_dest_idx[0] = d0;
    bus.dp_dest_idx[1] = d1;
    bus.dp_dest_idx[2] = d2;
  endtask

  task automatic set_cdb(input int lane, input logic [4:0] tag);
    bus.cdb_valid[lane] = 1'b1;
    bus.cdb_tag[lane]   = tag;
    bus.cdb_value[lane] = 32'h1000 + 32'(tag);
    bus.cdb_npc[lane]   = 32'h100;
  endtask

  task automatic cyc();
    @(negedge clock);
    clr();
  endtask

  // Complete n tags from base upward, 3 per cycle, then wait for the buffer to empty.
  task automatic drain(input int n, input int base);
    int sent = 0;
    int retired = 0;
    int guard = 0;
    while ((sent < n || bus.free_count != 6'd32) && guard < 40) begin
      cyc();
      for (int l = 0; l < 3; l++) begin
        if (sent < n) begin
          set_cdb(l, 5'((base + sent) % 32));
          sent++;
        end
      end
      #1;
      retired += $countones(bus.rt_valid);
      guard++;
    end
    chk("drain retired", 64'(retired), 64'(n));
    chk("drain free", bus.free_count, 32);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //        dpv     d0    d1    d2    cv      t0    t1    t2    cbr     lut   acc     tag0  free   rtv     r0    r1    r2    sq    lur
    tbl[0] = '{3'b111,5'd5, 5'd6, 5'd7, 3'b000,5'd0, 5'd0, 5'd0, 3'b000,5'd0, 3'b111,5'd0, 6'd32,3'b000,5'd0, 5'd0, 5'd0, 1'b0,1'b0};
    tbl[1] = '{3'b000,5'd0, 5'd0, 5'd0, 3'b011,5'd1, 5'd2, 5'd0, 3'b000,5'd0, 3'b000,5'd3, 6'd29,3'b000,5'd0, 5'd0, 5'd0, 1'b0,1'b0};
    tbl[2] = '{3'b000,5'd0, 5'd0, 5'd0, 3'b001,5'd0, 5'd0, 5'd0, 3'b000,5'd1, 3'b000,5'd3, 6'd29,3'b000,5'd0, 5'd0, 5'd0, 1'b0,1'b1};
    tbl[3] = '{3'b000,5'd0, 5'd0, 5'd0, 3'b000,5'd0, 5'd0, 5'd0, 3'b000,5'd2, 3'b000,5'd3, 6'd29,3'b111,5'd5, 5'd6, 5'd7, 1'b0,1'b1};
    tbl[4] = '{3'b000,5'd0, 5'd0, 5'd0, 3'b000,5'd0, 5'd0, 5'd0, 3'b000,5'd0, 3'b000,5'd3, 6'd32,3'b000,5'd0, 5'd0, 5'd0, 1'b0,1'b0};
    tbl[5] = '{3'b111,5'd1, 5'd2, 5'd3, 3'b000,5'd0, 5'd0, 5'd0, 3'b000,5'd0, 3'b111,5'd3, 6'd32,3'b000,5'd0, 5'd0, 5'd0, 1'b0,1'b0};
    tbl[6] = '{3'b000,5'd0, 5'd0, 5'd0, 3'b111,5'd3, 5'd4, 5'd5, 3'b010,5'd6, 3'b000,5'd6, 6'd29,3'b000,5'd0, 5'd0, 5'd0, 1'b0,1'b0};
    tbl[7] = '{3'b111,5'd8, 5'd9, 5'd10,3'b000,5'd0, 5'd0, 5'd0, 3'b000,5'd4, 3'b111,5'd6, 6'd29,3'b011,5'd1, 5'd2, 5'd0, 1'b1,1'b1};
    tbl[8] = '{3'b001,5'd11,5'd0, 5'd0, 3'b000,5'd0, 5'd0, 5'd0, 3'b000,5'd4, 3'b001,5'd0, 6'd32,3'b000,5'd0, 5'd0, 5'd0, 1'b0,1'b0};
    tbl[9] = '{3'b000,5'd0, 5'd0, 5'd0, 3'b000,5'd0, 5'd0, 5'd0, 3'b000,5'd0, 3'b000,5'd1, 6'd31,3'b000,5'd0, 5'd0, 5'd0, 1'b0,1'b0};

    reset = 1'b1;
    clr();
    repeat (3) @(negedge clock);
    #1;
    chk("reset free_count", bus.free_count, 32);
    chk("reset rt_valid", bus.rt_valid, 0);
    chk("reset dp_accept", bus.dp_accept, 0);
    chk("reset lu_ready", bus.lu_ready, 0);
    chk("reset rt_squash", bus.rt_squash, 0);

    for (int k = 0; k < 10; k++) begin
      cyc();
      reset = 1'b0;
      set_dp(tbl[k].dpv, tbl[k].d0, tbl[k].d1, tbl[k].d2);
      bus.cdb_valid  = tbl[k].cv;
      bus.cdb_tag[0] = tbl[k].t0;
      bus.cdb_tag[1] = tbl[k].t1;
      bus.cdb_tag[2] = tbl[k].t2;
      for (int c = 0; c < 3; c++) begin
        bus.cdb_value[c] = 32'h1000 + 32'(bus.cdb_tag[c]);
        bus.cdb_npc[c]   = 32'h100;
      end
      bus.cdb_take_branch = tbl[k].cbr;
      bus.lu_tag[0]       = tbl[k].lut;
      #1;
      chk($sformatf("v%0d dp_accept", k), bus.dp_accept, tbl[k].acc);
      if (tbl[k].acc != 3'b000) chk($sformatf("v%0d dp_tag0", k), bus.dp_tag[0], tbl[k].tag0);
      chk($sformatf("v%0d free_count", k), bus.free_count, tbl[k].free);
      chk($sformatf("v%0d rt_valid", k), bus.rt_valid, tbl[k].rtv);
      chk($sformatf("v%0d rt_dest0", k), bus.rt_dest_idx[0], tbl[k].r0);
      chk($sformatf("v%0d rt_dest1", k), bus.rt_dest_idx[1], tbl[k].r1);
      chk($sformatf("v%0d rt_dest2", k), bus.rt_dest_idx[2], tbl[k].r2);
      chk($sformatf("v%0d rt_squash", k), bus.rt_squash, tbl[k].sq);
      if (tbl[k].sq) chk($sformatf("v%0d rt_npc", k), bus.rt_npc, 32'h100);
      chk($sformatf("v%0d lu_ready", k), bus.lu_ready[0], tbl[k].lur);
    end

    // External squash drops the concurrent dispatch.
    cyc(); bus.squash = 1'b1; set_dp(3'b111, 5'd1, 5'd2, 5'd3);
    cyc(); #1;
    chk("squash free_count", bus.free_count, 32);

    // Fill to 30, then only two lanes fit, then full.
    for (int k = 0; k < 10; k++) begin
      cyc(); set_dp(3'b111, 5'(k), 5'(k), 5'(k)); #1;
      chk($sformatf("fill%0d dp_accept", k), bus.dp_accept, 3'b111);
      chk($sformatf("fill%0d dp_tag0", k), bus.dp_tag[0], 3 * k);
      chk($sformatf("fill%0d free", k), bus.free_count, 32 - 3 * k);
    end
    cyc(); set_dp(3'b111, 5'd1, 5'd1, 5'd1); #1;
    chk("near-full dp_accept", bus.dp_accept, 3'b011);
    chk("near-full free", bus.free_count, 2);
    cyc(); set_dp(3'b111, 5'd1, 5'd1, 5'd1); #1;
    chk("full dp_accept", bus.dp_accept, 3'b000);
    chk("full free", bus.free_count, 0);
    chk("full tail index", bus.dp_tag[0], 0);
    drain(32, 0);

    // Move head to index 30.
    for (int k = 0; k < 10; k++) begin
      cyc(); set_dp(3'b111, 5'd2, 5'd2, 5'd2);
    end
    drain(30, 0);

    // Dispatch and retire group straddling entry 31 -> 0.
    cyc(); set_dp(3'b111, 5'd1, 5'd2, 5'd3); #1;
    chk("wrap dp_accept", bus.dp_accept, 3'b111);
    chk("wrap dp_tag0", bus.dp_tag[0], 30);
    chk("wrap dp_tag1", bus.dp_tag[1], 31);
    chk("wrap dp_tag2", bus.dp_tag[2], 0);
    cyc(); set_cdb(0, 5'd30); set_cdb(1, 5'd31); set_cdb(2, 5'd0);
    cyc(); #1;
    chk("wrap rt_valid", bus.rt_valid, 3'b111);
    chk("wrap rt_dest0", bus.rt_dest_idx[0], 1);
    chk("wrap rt_dest2", bus.rt_dest_idx[2], 3);
    chk("wrap rt_value2", bus.rt_value[2], 32'h1000);
    cyc(); #1;
    chk("wrap free", bus.free_count, 32);

    // Halt stops retirement after the halting entry; no redirect.
    cyc(); set_dp(3'b111, 5'd4, 5'd5, 5'd6); #1;
    chk("halt dp_tag0", bus.dp_tag[0], 1);
    cyc(); set_cdb(0, 5'd1); set_cdb(1, 5'd2); set_cdb(2, 5'd3); bus.cdb_halt = 3'b001;
    cyc(); #1;
    chk("halt rt_valid", bus.rt_valid, 3'b001);
    chk("halt rt_halt", bus.rt_halt, 1);
    chk("halt rt_squash", bus.rt_squash, 0);
    chk("halt rt_dest0", bus.rt_dest_idx[0], 4);
    cyc(); #1;
    chk("post-halt rt_valid", bus.rt_valid, 3'b011);
    chk("post-halt rt_dest0", bus.rt_dest_idx[0], 5);
    chk("post-halt rt_dest1", bus.rt_dest_idx[1], 6);
    chk("post-halt rt_halt", bus.rt_halt, 0);
    cyc(); #1;
    chk("post-halt free", bus.free_count, 32);

    // Lookup against a same-cycle completion.
    cyc(); bus.squash = 1'b1;
    cyc(); set_dp(3'b111, 5'd1, 5'd2, 5'd3);
    cyc(); set_dp(3'b111, 5'd4, 5'd5, 5'd6);
    cyc(); set_cdb(1, 5'd4); bus.cdb_value[1] = 32'hDEAD; bus.lu_tag[0] = 5'd4; bus.lu_tag[3] = 5'd5; #1;
`ifdef ROB_CDB_BYPASS_EN
    chk("bypass lu_ready", bus.lu_ready[0], 1);
    chk("bypass lu_value", bus.lu_value[0], 32'hDEAD);
`else
    chk("no-bypass lu_ready", bus.lu_ready[0], 0);
`endif
    chk("lookup busy-not-done", bus.lu_ready[3], 0);
    cyc(); bus.lu_tag[5] = 5'd4; #1;
    chk("lookup stored ready", bus.lu_ready[5], 1);
    chk("lookup stored value", bus.lu_value[5], 32'hDEAD);

    // Reset discards same-cycle dispatch and completion.
    cyc(); reset = 1'b1; set_dp(3'b111, 5'd7, 5'd7, 5'd7); set_cdb(0, 5'd0);
    cyc(); reset = 1'b0; bus.lu_tag[0] = 5'd4; set_dp(3'b001, 5'd9, 5'd0, 5'd0); #1;
    chk("mid-reset free", bus.free_count, 32);
    chk("mid-reset dp_accept", bus.dp_accept, 3'b001);
    chk("mid-reset dp_tag0", bus.dp_tag[0], 0);
    chk("mid-reset rt_valid", bus.rt_valid, 0);
    chk("mid-reset lu_ready", bus.lu_ready[0], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
